// File: rtl/cordic_iter_ctrl_if.sv
// Handshake bundle for the iterative CORDIC rotator: request side (vector + angle)
// and result side (rotated vector + residual angle).
interface cordic_iter_ctrl_if #(parameter int WIDTH = 16);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] target_angle;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] angle_out;
  logic [3:0]              iter_idx;

  modport master (
    output in_valid, x_in, y_in, target_angle, out_ready,
    input  in_ready, out_valid, x_out, y_out, angle_out, iter_idx
  );
  modport slave (
    input  in_valid, x_in, y_in, target_angle, out_ready,
    output in_ready, out_valid, x_out, y_out, angle_out, iter_idx
  );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, ITER rotations per
// operation, result held in DONE until the consumer takes it.
module cordic_iter_ctrl #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input logic               clk,
  input logic               rst_n,
  cordic_iter_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t                  state;
  logic [3:0]              i;
  logic signed [WIDTH-1:0] xw, yw, zw;
  logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic signed [WIDTH-1:0] y_sh, x_sh, atan_i;
  logic signed [WIDTH-1:0] x_out_r, y_out_r, z_out_r;
  logic                    in_ready_r, out_valid_r;

  // atan(2^-k) in Q2.13, round-to-nearest
  function automatic logic signed [WIDTH-1:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = WIDTH'(6434);
      4'd1:    atan_lut = WIDTH'(3798);
      4'd2:    atan_lut = WIDTH'(2007);
      4'd3:    atan_lut = WIDTH'(1019);
      4'd4:    atan_lut = WIDTH'(511);
      4'd5:    atan_lut = WIDTH'(256);
      4'd6:    atan_lut = WIDTH'(128);
      4'd7:    atan_lut = WIDTH'(64);
      4'd8:    atan_lut = WIDTH'(32);
      4'd9:    atan_lut = WIDTH'(16);
      4'd10:   atan_lut = WIDTH'(8);
      4'd11:   atan_lut = WIDTH'(4);
      4'd12:   atan_lut = WIDTH'(2);
      4'd13:   atan_lut = WIDTH'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  always_comb begin
    y_sh   = yw >>> i;
    x_sh   = xw >>> i;
    atan_i = atan_lut(i);
    // rotate toward zero residual: positive z rotates counter-clockwise
    if (!zw[WIDTH-1]) begin
      x_nx = xw - y_sh;
      y_nx = yw + x_sh;
      z_nx = zw - atan_i;
    end else begin
      x_nx = xw + y_sh;
      y_nx = yw - x_sh;
      z_nx = zw + atan_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      i           <= '0;
      xw          <= '0;
      yw          <= '0;
      zw          <= '0;
      x_out_r     <= '0;
      y_out_r     <= '0;
      z_out_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          xw         <= bus.x_in;
          yw         <= bus.y_in;
          zw         <= bus.target_angle;
          i          <= '0;
          in_ready_r <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          xw <= x_nx;
          yw <= y_nx;
          zw <= z_nx;
          if (i == LAST) begin
            x_out_r     <= x_nx;
            y_out_r     <= y_nx;
            z_out_r     <= z_nx;
            i           <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            i <= i + 4'd1;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.x_out     = x_out_r;
  assign bus.y_out     = y_out_r;
  assign bus.angle_out = z_out_r;
  assign bus.iter_idx  = i;
endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
Iterative rotation-mode CORDIC engine for the vector-rotation datapath. It latches an input vector (x_in, y_in) and a target angle, then runs one micro-rotation per clock: x/y shift-add/sub plus angle-accumulator update, steered by the sign of the residual angle. It generates the per-iteration arithmetic shifts and arctangent constants internally. It presents the rotated vector and the residual angle through a valid/ready output handshake.

Parameters:
WIDTH, 16, data and angle word width (signed two's complement); only 16 is supported.
ITER, 16, number of micro-rotations per operation; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  request to start a rotation
in_ready  output  1  high only in IDLE; a transfer occurs when in_valid && in_ready at a rising edge
x_in  input  16  signed initial x
y_in  input  16  signed initial y
target_angle  input  16  signed angle, Q2.13 radians (1 LSB = 2^-13 rad); legal range [-12868, +12868] (±π/2)
out_valid  output  1  result available; high only in DONE
out_ready  input  1  consumer accepts result
x_out  output  16  signed rotated x (includes CORDIC gain K ≈ 1.64676, uncompensated)
y_out  output  16  signed rotated y
angle_out  output  16  signed residual angle z after the last iteration, Q2.13
iter_idx  output  4  current iteration index (debug)

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst_n low at a rising edge) forces IDLE. It also clears the working registers, x_out, y_out, angle_out and iter_idx to 0, and drives out_valid to 0. Reset takes priority over every other event, including mid-RUN. A reset mid-RUN discards the operation; no out_valid follows.
- IDLE: in_ready = 1. On a transfer, latch xw = x_in, yw = y_in, zw = target_angle, set i = 0, and go to RUN.
- RUN: in_ready = 0. At each edge:
  - d = (zw >= 0).
  - If d: xw <= xw - (yw >>> i); yw <= yw + (xw >>> i); zw <= zw - atan[i].
  - Else: xw <= xw + (yw >>> i); yw <= yw - (xw >>> i); zw <= zw + atan[i].
  - The right-hand sides use the pre-edge register values.
  - >>> is an arithmetic, sign-extending shift.
  - All sums are WIDTH-bit with two's-complement wrap-around; there is no saturation.
  - i increments by 1 each edge. When i == ITER-1, the same edge copies the updated xw/yw/zw into x_out/y_out/angle_out and moves to DONE.
- atan[i] in Q2.13 (round-to-nearest, i = 0..15): 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0.
- Latency: if the transfer occurs at edge E, out_valid is first high in the cycle after edge E+ITER, i.e. exactly ITER cycles after the accepting cycle.
- DONE: out_valid = 1, in_ready = 0. x_out, y_out and angle_out are held stable; in_valid is ignored.
  - On out_valid && out_ready at an edge, go to IDLE. out_valid falls and in_ready rises in the next cycle.
  - x_out, y_out and angle_out keep their values until the next DONE entry or reset.
- Throughput: one result per ITER+2 cycles at most. There is no pipelining or overlap.
- The working registers are internal. Only iter_idx (= i) is visible during RUN; it is 0 in IDLE and DONE.
- Input bounding for overflow-free operation: |x_in|, |y_in| ≤ 9000. Outside this range, wrap-around is the defined behaviour.
- Targets outside ±π/2 are not flagged. The result is then a non-converged rotation, with residual angle_out reflecting the error.

Test Plan:
- x_in=4096, y_in=0, target=0, ITER=16 -> x_out=6745±4, y_out=0±4, |angle_out|≤2; out_valid high exactly 16 cycles after the accept cycle.
- x_in=4096, y_in=0, target=6434 (π/4) -> x_out=4769±4, y_out=4769±4.
- x_in=4096, y_in=0, target=-12868 (-π/2) -> x_out=0±4, y_out=-6745±4.
- Result ready, out_ready held low for 5 cycles, in_valid pulsed during DONE -> outputs stable, in_ready=0, pulse ignored. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 next cycle; a new transfer is then accepted.
- rst_n low for one edge while iter_idx=7 -> next cycle state IDLE, all outputs 0, out_valid never asserts for the aborted operation.
- Boundary: x_in=-9000, y_in=9000, target=12868 -> x_out=-14821±6, y_out=-14821±6, no wrap (K·9000 ≈ 14821 per component).
